// File: rtl/ppm_tx_pkg.sv
// Shared definitions for the PPM transmitter: frame geometry and scheduler state encoding.
// Also imported by the frame buffer.
package ppm_tx_pkg;

  localparam int unsigned PPM_MAX_BYTES = 16;
  localparam int unsigned PPM_LEN_W     = 4;
  localparam int unsigned PPM_BYTE_W    = 8;
  localparam int unsigned PPM_GUARD_W   = 8;
  localparam int unsigned PPM_TMO_W     = 16;

  localparam logic [4:0] PPM_ST_IDLE    = 5'b00001;
  localparam logic [4:0] PPM_ST_COLLECT = 5'b00010;
  localparam logic [4:0] PPM_ST_BURST   = 5'b00100;
  localparam logic [4:0] PPM_ST_WAIT    = 5'b01000;
  localparam logic [4:0] PPM_ST_GUARD   = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE    = PPM_ST_IDLE,
    ST_COLLECT = PPM_ST_COLLECT,
    ST_BURST   = PPM_ST_BURST,
    ST_WAIT    = PPM_ST_WAIT,
    ST_GUARD   = PPM_ST_GUARD
  } ppm_state_e;

endpackage

// File: rtl/ppm_tx_scheduler_stage_ram.sv
// 16x8 staging register file: synchronous write, registered read with write-first forwarding.
module ppm_stage_ram
  import ppm_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [PPM_LEN_W-1:0]  i_waddr,
  input  logic [PPM_BYTE_W-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [PPM_LEN_W-1:0]  i_raddr,
  output logic [PPM_BYTE_W-1:0] o_rdata
);

  logic [PPM_BYTE_W-1:0] r_mem [PPM_MAX_BYTES];
  logic [PPM_BYTE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Forwarding covers a single-byte frame, whose only byte is read on the edge it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ppm_tx_scheduler.sv
// Round-robin frame scheduler: grants one of two byte sources, stages the frame,
// bursts it into the frame buffer, waits for frame_done (or timeout), then guards.
module ppm_tx_scheduler
  import ppm_tx_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic [PPM_LEN_W-1:0]  i_len0,
  input  logic [PPM_LEN_W-1:0]  i_len1,
  input  logic                  i_d0_valid,
  input  logic                  i_d1_valid,
  input  logic [PPM_BYTE_W-1:0] i_d0,
  input  logic [PPM_BYTE_W-1:0] i_d1,
  output logic                  o_d0_ready,
  output logic                  o_d1_ready,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_buf_le,
  output logic [PPM_LEN_W-1:0]  o_buf_n,
  output logic [PPM_BYTE_W-1:0] o_buf_din,
  input  logic                  i_buf_frame_done,
  output logic                  o_busy,
  output logic                  o_err_timeout
);

  localparam logic [PPM_GUARD_W-1:0] GUARD_LAST = PPM_GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [PPM_TMO_W-1:0]   TMO_LAST   = PPM_TMO_W'(TIMEOUT_CYCLES - 1);

  ppm_state_e             r_state, w_state_nxt;
  logic                   r_rr, w_rr_nxt;
  logic                   r_sel, w_sel_nxt;
  logic [PPM_LEN_W-1:0]   r_len_q, w_len_nxt;
  logic [PPM_LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [PPM_GUARD_W-1:0] r_gcnt, w_gcnt_nxt;
  logic [PPM_TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic                   r_gnt0, w_gnt0_nxt;
  logic                   r_gnt1, w_gnt1_nxt;
  logic                   r_d0_ready, w_rdy0_nxt;
  logic                   r_d1_ready, w_rdy1_nxt;
  logic                   r_buf_le, w_le_nxt;
  logic [PPM_LEN_W-1:0]   r_buf_n, w_n_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_err, w_err_nxt;

  logic                   w_g1;
  logic                   w_accept;
  logic                   w_last;
  logic [PPM_BYTE_W-1:0]  w_wdata;
  logic                   w_re;
  logic [PPM_LEN_W-1:0]   w_raddr;
  logic [PPM_BYTE_W-1:0]  w_rdata;

  // Only the granted source ever sees ready, so the accept OR is unambiguous.
  assign w_accept = (r_d0_ready & i_d0_valid) | (r_d1_ready & i_d1_valid);
  assign w_last   = w_accept && (r_cnt == r_len_q);
  assign w_wdata  = r_sel ? i_d1 : i_d0;

  ppm_stage_ram u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept),
    .i_waddr (r_cnt),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_sel      <= 1'b0;
      r_len_q    <= '0;
      r_cnt      <= '0;
      r_gcnt     <= '0;
      r_tmo      <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_d0_ready <= 1'b0;
      r_d1_ready <= 1'b0;
      r_buf_le   <= 1'b0;
      r_buf_n    <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr       <= w_rr_nxt;
      r_sel      <= w_sel_nxt;
      r_len_q    <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_d0_ready <= w_rdy0_nxt;
      r_d1_ready <= w_rdy1_nxt;
      r_buf_le   <= w_le_nxt;
      r_buf_n    <= w_n_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_sel_nxt   = r_sel;
    w_len_nxt   = r_len_q;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    w_tmo_nxt   = r_tmo;
    w_gnt0_nxt  = r_gnt0;
    w_gnt1_nxt  = r_gnt1;
    w_rdy0_nxt  = 1'b0;
    w_rdy1_nxt  = 1'b0;
    w_le_nxt    = 1'b0;
    w_n_nxt     = r_buf_n;
    w_err_nxt   = 1'b0;
    w_g1        = 1'b0;
    w_re        = 1'b0;
    w_raddr     = PPM_LEN_W'(r_cnt + 1'b1);

    case (r_state)
      ST_IDLE: begin
        // r_rr set means ch1 is favoured on a tie.
        if (i_req0 || i_req1) begin
          w_g1        = i_req1 & (~i_req0 | r_rr);
          w_sel_nxt   = w_g1;
          w_rr_nxt    = ~w_g1;
          w_gnt0_nxt  = ~w_g1;
          w_gnt1_nxt  = w_g1;
          w_rdy0_nxt  = ~w_g1;
          w_rdy1_nxt  = w_g1;
          w_len_nxt   = w_g1 ? i_len1 : i_len0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        w_rdy0_nxt = ~r_sel;
        w_rdy1_nxt = r_sel;
        if (w_last) begin
          w_rdy0_nxt  = 1'b0;
          w_rdy1_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_le_nxt    = 1'b1;
          w_n_nxt     = r_len_q;
          w_re        = 1'b1;
          w_raddr     = '0;
          w_state_nxt = ST_BURST;
        end else if (w_accept) begin
          w_cnt_nxt = PPM_LEN_W'(r_cnt + 1'b1);
        end
      end
      ST_BURST: begin
        // r_cnt indexes the byte currently on buf_din.
        if (r_cnt == r_len_q) begin
          w_tmo_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_cnt_nxt = PPM_LEN_W'(r_cnt + 1'b1);
          w_le_nxt  = 1'b1;
          w_re      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_buf_frame_done || (r_tmo == TMO_LAST)) begin
          w_err_nxt   = ~i_buf_frame_done;
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
          w_gcnt_nxt  = '0;
          w_state_nxt = ST_GUARD;
        end else begin
          w_tmo_nxt = PPM_TMO_W'(r_tmo + 1'b1);
        end
      end
      ST_GUARD: begin
        if (r_gcnt == GUARD_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gcnt_nxt = PPM_GUARD_W'(r_gcnt + 1'b1);
        end
      end
      default: begin
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign o_d0_ready    = r_d0_ready;
  assign o_d1_ready    = r_d1_ready;
  assign o_gnt0        = r_gnt0;
  assign o_gnt1        = r_gnt1;
  assign o_buf_le      = r_buf_le;
  assign o_buf_n       = r_buf_n;
  assign o_buf_din     = w_rdata;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_ppm_tx_scheduler.sv
// Self-checking bench for ppm_tx_scheduler: frame-level reference model with
// round-robin prediction, cycle-exact burst/guard/timeout expectations.
module tb_ppm_tx_scheduler;

  localparam int unsigned GUARD = 16;
  localparam int unsigned TMO   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_req0, i_req1;
  logic [3:0] i_len0, i_len1;
  logic       i_d0_valid, i_d1_valid;
  logic [7:0] i_d0, i_d1;
  logic       o_d0_ready, o_d1_ready, o_gnt0, o_gnt1, o_buf_le;
  logic [3:0] o_buf_n;
  logic [7:0] o_buf_din;
  logic       i_buf_frame_done;
  logic       o_busy, o_err_timeout;

  int n_vec   = 0;
  int n_err   = 0;
  int le_seen = 0;
  int m_pref  = 0;

  ppm_tx_scheduler #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req0           (i_req0),
    .i_req1           (i_req1),
    .i_len0           (i_len0),
    .i_len1           (i_len1),
    .i_d0_valid       (i_d0_valid),
    .i_d1_valid       (i_d1_valid),
    .i_d0             (i_d0),
    .i_d1             (i_d1),
    .o_d0_ready       (o_d0_ready),
    .o_d1_ready       (o_d1_ready),
    .o_gnt0           (o_gnt0),
    .o_gnt1           (o_gnt1),
    .o_buf_le         (o_buf_le),
    .o_buf_n          (o_buf_n),
    .o_buf_din        (o_buf_din),
    .i_buf_frame_done (i_buf_frame_done),
    .o_busy           (o_busy),
    .o_err_timeout    (o_err_timeout)
  );

  always #5 clk = ~clk;

  // Running count of cycles with buf_le high, sampled mid-low-phase.
  always begin
    @(negedge clk);
    #2;
    if (o_buf_le === 1'b1) le_seen++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One complete frame; entered and left at a negedge of an IDLE cycle.
  task automatic do_frame(input bit rq0, input bit rq1, input int len_sel, input int dbase,
                          input int stall_mode, input bit tmo, input bit spur, input bit hold);
    logic [3:0] l0, l1, len;
    logic [7:0] data [16];
    int         ch, k, cyc, le0, wait_d;
    bit         v;
    l0 = (len_sel >= 0) ? 4'(len_sel) : 4'($urandom);
    l1 = (len_sel >= 0) ? 4'(len_sel) : 4'($urandom);
    ch = (rq0 && rq1) ? m_pref : (rq1 ? 1 : 0);
    len = (ch == 1) ? l1 : l0;
    for (int i = 0; i < 16; i++) data[i] = (dbase >= 0) ? 8'(dbase + i) : 8'($urandom);

    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++; $display("FAIL idle_entry: busy=%b expected 0", o_busy);
    end
    le0 = le_seen;
    i_req0 = rq0; i_req1 = rq1; i_len0 = l0; i_len1 = l1; i_buf_frame_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({o_gnt0, o_gnt1, o_busy} !== {(ch == 0), (ch == 1), 1'b1}) begin
      n_err++; $display("FAIL grant: gnt0,gnt1,busy=%b expected %b", {o_gnt0, o_gnt1, o_busy},
                        {(ch == 0), (ch == 1), 1'b1});
    end
    if (!hold) begin i_req0 = 1'b0; i_req1 = 1'b0; end
    i_len0 = 4'($urandom); i_len1 = 4'($urandom);

    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < 200) begin
      n_vec++;
      if ({o_d0_ready, o_d1_ready, o_buf_le} !== {(ch == 0), (ch == 1), 1'b0}) begin
        n_err++; $display("FAIL collect: rdy0,rdy1,le=%b expected %b",
                          {o_d0_ready, o_d1_ready, o_buf_le}, {(ch == 0), (ch == 1), 1'b0});
      end
      case (stall_mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = ((cyc % 2) == 1);
      endcase
      if (ch == 0) begin
        i_d0_valid = v; i_d0 = data[k]; i_d1_valid = 1'b1; i_d1 = 8'($urandom);
      end else begin
        i_d1_valid = v; i_d1 = data[k]; i_d0_valid = 1'b1; i_d0 = 8'($urandom);
      end
      i_buf_frame_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (v) k++;
      cyc++;
    end
    n_vec++;
    if (cyc >= 200) begin
      n_err++; $display("FAIL collect_budget: %0d bytes taken expected %0d", k, int'(len) + 1);
    end
    i_d0_valid = 1'b0; i_d1_valid = 1'b0;

    for (int j = 0; j <= int'(len); j++) begin
      n_vec++;
      if ({o_buf_le, o_buf_din, o_buf_n, o_d0_ready, o_d1_ready} !== {1'b1, data[j], len, 2'b00}) begin
        n_err++; $display("FAIL burst[%0d]: le,din,n,rdy=%h expected %h", j,
                          {o_buf_le, o_buf_din, o_buf_n, o_d0_ready, o_d1_ready},
                          {1'b1, data[j], len, 2'b00});
      end
      i_buf_frame_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    i_buf_frame_done = 1'b0;

    wait_d = tmo ? int'(TMO) : int'($urandom_range(0, 5));
    for (int i = 0; i < wait_d; i++) begin
      n_vec++;
      if ({o_buf_le, o_buf_n, o_gnt0, o_gnt1, o_err_timeout} !== {1'b0, len, (ch == 0), (ch == 1), 1'b0}) begin
        n_err++; $display("FAIL wait[%0d]: le,n,gnt0,gnt1,err=%b expected %b", i,
                          {o_buf_le, o_buf_n, o_gnt0, o_gnt1, o_err_timeout},
                          {1'b0, len, (ch == 0), (ch == 1), 1'b0});
      end
      @(negedge clk);
    end
    if (!tmo) begin
      i_buf_frame_done = 1'b1;
      @(negedge clk);
      i_buf_frame_done = 1'b0;
    end

    n_vec++;
    if ({o_gnt0, o_gnt1, o_err_timeout, o_busy} !== {1'b0, 1'b0, tmo, 1'b1}) begin
      n_err++; $display("FAIL guard_entry: gnt0,gnt1,err,busy=%b expected %b",
                        {o_gnt0, o_gnt1, o_err_timeout, o_busy}, {1'b0, 1'b0, tmo, 1'b1});
    end
    for (int i = 1; i < int'(GUARD); i++) begin
      @(negedge clk);
      n_vec++;
      if ({o_gnt0, o_gnt1, o_err_timeout, o_busy, o_buf_le} !== 5'b00010) begin
        n_err++; $display("FAIL guard[%0d]: gnt0,gnt1,err,busy,le=%b expected 00010", i,
                          {o_gnt0, o_gnt1, o_err_timeout, o_busy, o_buf_le});
      end
    end
    @(negedge clk);
    n_vec++;
    if ({o_gnt0, o_gnt1, o_busy} !== 3'b000) begin
      n_err++; $display("FAIL idle_return: gnt0,gnt1,busy=%b expected 000", {o_gnt0, o_gnt1, o_busy});
    end
    n_vec++;
    if (le_seen - le0 !== int'(len) + 1) begin
      n_err++; $display("FAIL le_count: %0d buf_le cycles expected %0d", le_seen - le0, int'(len) + 1);
    end
    m_pref = 1 - ch;
    i_req0 = 1'b0; i_req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_gnt0, o_gnt1, o_d0_ready, o_d1_ready, o_buf_le, o_buf_n, o_buf_din, o_busy, o_err_timeout} !== '0) begin
      n_err++; $display("FAIL reset_values: outputs=%h expected 0",
                        {o_gnt0, o_gnt1, o_d0_ready, o_d1_ready, o_buf_le, o_buf_n, o_buf_din, o_busy, o_err_timeout});
    end
    rst_n = 1'b1;
    m_pref = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_gnt0, o_gnt1, o_busy, o_buf_le} !== 4'b0000) begin
      n_err++; $display("FAIL idle_after_reset: gnt0,gnt1,busy,le=%b expected 0000",
                        {o_gnt0, o_gnt1, o_busy, o_buf_le});
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++) do_frame(1'b1, 1'b1, 0, -1, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    do_frame(1'b1, 1'b0, 3, 8'hA1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_long();
    do_frame(1'b0, 1'b1, 15, 0, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_frame(1'b1, 1'b0, -1, -1, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_spurious();
    do_frame(1'b1, 1'b0, 7, -1, 1, 1'b0, 1'b1, 1'b0);
    do_frame(1'b0, 1'b1, 2, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int rq;
    for (int i = 0; i < 10; i++) begin
      rq = int'($urandom_range(1, 3));
      do_frame(rq[0], rq[1], -1, -1, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midburst();
    int le0;
    i_req0 = 1'b1; i_len0 = 4'd5;
    @(negedge clk);
    i_req0 = 1'b0;
    n_vec++;
    if ({o_gnt0, o_d0_ready} !== 2'b11) begin
      n_err++; $display("FAIL rst_grant: gnt0,rdy0=%b expected 11", {o_gnt0, o_d0_ready});
    end
    for (int k = 0; k < 6; k++) begin
      i_d0_valid = 1'b1; i_d0 = 8'(8'h30 + k);
      @(negedge clk);
    end
    i_d0_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      n_vec++;
      if ({o_buf_le, o_buf_din} !== {1'b1, 8'(8'h30 + j)}) begin
        n_err++; $display("FAIL rst_burst[%0d]: le,din=%h expected %h", j, {o_buf_le, o_buf_din},
                          {1'b1, 8'(8'h30 + j)});
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_gnt0, o_gnt1, o_d0_ready, o_d1_ready, o_buf_le, o_buf_n, o_buf_din, o_busy, o_err_timeout} !== '0) begin
      n_err++; $display("FAIL rst_async: outputs=%h expected 0",
                        {o_gnt0, o_gnt1, o_d0_ready, o_d1_ready, o_buf_le, o_buf_n, o_buf_din, o_busy, o_err_timeout});
    end
    le0 = le_seen;
    m_pref = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if ((le_seen != le0) || (o_busy !== 1'b0)) begin
      n_err++; $display("FAIL stale_burst: %0d buf_le cycles, busy=%b expected 0 and 0",
                        le_seen - le0, o_busy);
    end
    do_frame(1'b0, 1'b1, -1, -1, 0, 1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b1, -1, -1, 1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_req0 = 1'b0; i_req1 = 1'b0; i_len0 = '0; i_len1 = '0;
    i_d0_valid = 1'b0; i_d1_valid = 1'b0; i_d0 = '0; i_d1 = '0;
    i_buf_frame_done = 1'b0;
    test_reset();
    test_alternate();
    test_single();
    test_stall_long();
    test_timeout();
    test_spurious();
    test_random();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
